// File: rtl/i2s_cap_pkg.sv
// Shared constants and helpers for the multi-channel I2S capture path.
package i2s_cap_pkg;

   localparam int unsigned SLOT_W     = 32;
   localparam int unsigned DROP_CNT_W = 16;

   // Capture FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Number of stream beats needed to carry one frame of num_ch slots
   function automatic int unsigned beats(input int unsigned num_ch,
                                         input int unsigned tdata_w);
      return (num_ch * SLOT_W) / tdata_w;
   endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO; a pop and a write in the same cycle succeed even when full.
module i2s_frame_fifo #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_write,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_wr;
   logic             w_do_pop;

   assign o_empty  = (r_wr_ptr == r_rd_ptr);
   assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop = i_pop && !o_empty;
   assign w_do_wr  = i_write && (!o_full || w_do_pop);
   assign o_rdata  = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge i_clk) begin
      if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/i2s_multi_capture_axis.sv
// N-channel I2S capture into a frame FIFO, emitted as an AXI-Stream master.
// Optional build macro I2S_CAP_TUSER_EN adds m_axis_tuser[0] carrying the frame slot.
module i2s_multi_capture_axis
   import i2s_cap_pkg::*;
#(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned SAMPLE_W   = 24,
   parameter int unsigned TDATA_W    = 128,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  sck,
   input  logic                  rst,
   input  logic                  ws,
   input  logic [NUM_CH-1:0]     sd,
   input  logic                  start,
   input  logic                  stereo_en,
   input  logic                  m_axis_tready,
   output logic [TDATA_W-1:0]    m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  overflow,
   output logic                  short_err,
   output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef I2S_CAP_TUSER_EN
   ,
   output logic [0:0]            m_axis_tuser
`endif
);

   localparam int unsigned FRAME_W = NUM_CH * SLOT_W;
   localparam int unsigned BEATS   = beats(NUM_CH, TDATA_W);
   localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CNT_W   = $clog2(SAMPLE_W + 1);
`ifdef I2S_CAP_TUSER_EN
   localparam int unsigned FIFO_W  = FRAME_W + 1;
`else
   localparam int unsigned FIFO_W  = FRAME_W;
`endif

   logic [1:0]                       r_state;
   logic [1:0]                       w_state_nxt;
   logic                             r_ws_q;
   logic [CNT_W-1:0]                 r_bit_cnt;
   logic [NUM_CH-1:0][SAMPLE_W-1:0]  r_shreg;
   logic                             r_overflow;
   logic                             r_short_err;
   logic [DROP_CNT_W-1:0]            r_drop_cnt;
   logic                             w_edge;
   logic                             w_elig;
   logic                             w_arm_shift;
   logic                             w_shift;
   logic                             w_short;
   logic                             w_wr;
   logic                             w_ovf;
   logic [FRAME_W-1:0]               w_frame;
   logic [FIFO_W-1:0]                w_fifo_wdata;
   logic [FIFO_W-1:0]                w_fifo_rdata;
   logic                             w_full;
   logic                             w_empty;
   logic                             w_pop;
   logic [FRAME_W-1:0]               w_rd_frame;
   logic [BEAT_W-1:0]                w_beat_sel;
   logic [TDATA_W-1:0]               w_beat_data;
   logic                             w_last_nxt;
   logic [BEAT_W-1:0]                r_beat;
   logic [TDATA_W-1:0]               r_tdata;
   logic                             r_tvalid;
   logic                             r_tlast;
`ifdef I2S_CAP_TUSER_EN
   logic                             r_slot;
   logic                             r_tuser;
`endif

   assign w_edge = ws ^ r_ws_q;
   assign w_elig = !ws || stereo_en;

   // Capture FSM state register
   always_ff @(posedge sck or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Capture FSM next state and per-cycle strobes
   always_comb begin
      w_state_nxt = r_state;
      w_arm_shift = 1'b0;
      w_shift     = 1'b0;
      w_short     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_ARM;
         end
         ST_ARM: begin
            if (!start) begin
               w_state_nxt = ST_IDLE;
            end else if (w_edge && w_elig) begin
               w_state_nxt = ST_SHIFT;
               w_arm_shift = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_edge) begin
               // slot ended early: drop it, retarget onto the new slot if wanted
               w_short = 1'b1;
               if (start && w_elig) begin
                  w_state_nxt = ST_SHIFT;
                  w_arm_shift = 1'b1;
               end else if (start) begin
                  w_state_nxt = ST_ARM;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_shift = 1'b1;
               if (r_bit_cnt == CNT_W'(SAMPLE_W - 1)) w_state_nxt = ST_DONE;
            end
         end
         default: begin
            // DONE can coincide with the next slot's edge on tight ws timing
            if (!start) begin
               w_state_nxt = ST_IDLE;
            end else if (w_edge && w_elig) begin
               w_state_nxt = ST_SHIFT;
               w_arm_shift = 1'b1;
            end else begin
               w_state_nxt = ST_ARM;
            end
         end
      endcase
   end

   // ws history and per-channel deserialisers
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         r_ws_q    <= 1'b0;
         r_bit_cnt <= '0;
         r_shreg   <= '0;
`ifdef I2S_CAP_TUSER_EN
         r_slot    <= 1'b0;
`endif
      end else begin
         r_ws_q <= ws;
         if (w_arm_shift) begin
            r_bit_cnt <= '0;
`ifdef I2S_CAP_TUSER_EN
            r_slot    <= ws;
`endif
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            for (int i = 0; i < int'(NUM_CH); i++) begin
               r_shreg[i] <= {r_shreg[i][SAMPLE_W-2:0], sd[i]};
            end
         end
      end
   end

   // Sign-extend every channel into its 32-bit slot, channel 0 lowest
   always_comb begin
      w_frame = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         w_frame[i*SLOT_W +: SLOT_W] = {{(SLOT_W-SAMPLE_W){r_shreg[i][SAMPLE_W-1]}}, r_shreg[i]};
      end
   end

   assign w_wr  = (r_state == ST_DONE) && (!w_full || w_pop);
   assign w_ovf = (r_state == ST_DONE) && w_full && !w_pop;

`ifdef I2S_CAP_TUSER_EN
   assign w_fifo_wdata = {r_slot, w_frame};
`else
   assign w_fifo_wdata = w_frame;
`endif

   // Sticky error flags and saturating drop counter
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_short_err <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_ovf)   r_overflow  <= 1'b1;
         if (w_short) r_short_err <= 1'b1;
         if ((w_ovf || w_short) && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   i2s_frame_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (sck),
      .i_rst   (rst),
      .i_write (w_wr),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_rd_frame  = w_fifo_rdata[FRAME_W-1:0];
   assign w_pop       = r_tvalid && m_axis_tready && r_tlast;
   assign w_beat_sel  = r_tvalid ? (r_beat + BEAT_W'(1)) : '0;
   assign w_beat_data = TDATA_W'(w_rd_frame >> (32'(w_beat_sel) * TDATA_W));
   assign w_last_nxt  = (w_beat_sel == BEAT_W'(BEATS - 1));

   // Beat serialiser; the head frame stays in the FIFO until its last beat is taken
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         r_beat   <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
`ifdef I2S_CAP_TUSER_EN
         r_tuser  <= 1'b0;
`endif
      end else if (!r_tvalid || m_axis_tready) begin
         if (r_tvalid && r_tlast) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end else if (r_tvalid) begin
            r_beat  <= w_beat_sel;
            r_tdata <= w_beat_data;
            r_tlast <= w_last_nxt;
         end else if (!w_empty) begin
            r_beat   <= '0;
            r_tdata  <= w_beat_data;
            r_tlast  <= w_last_nxt;
            r_tvalid <= 1'b1;
`ifdef I2S_CAP_TUSER_EN
            r_tuser  <= w_fifo_rdata[FRAME_W];
`endif
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign overflow      = r_overflow;
   assign short_err     = r_short_err;
   assign drop_cnt      = r_drop_cnt;
`ifdef I2S_CAP_TUSER_EN
   assign m_axis_tuser  = r_tuser;
`endif

endmodule

// File: tb/tb_i2s_multi_capture_axis.sv
// Self-checking bench for i2s_multi_capture_axis at default parameters.
module tb_i2s_multi_capture_axis;

   typedef logic [7:0][23:0] smp_t;
   typedef struct { smp_t smp; logic [127:0] b0; logic [127:0] b1; } vec_t;
   typedef struct { logic [127:0] data; logic last; logic user; } beat_t;

   logic         sck = 1'b0;
   logic         rst = 1'b1;
   logic         ws = 1'b1;
   logic [7:0]   sd = '0;
   logic         start = 1'b0;
   logic         stereo_en = 1'b0;
   logic         tready = 1'b0;
   logic [127:0] tdata;
   logic         tvalid, tlast, overflow, short_err;
   logic [15:0]  drop_cnt;
`ifdef I2S_CAP_TUSER_EN
   logic [0:0]   tuser;
`endif

   beat_t q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    mode = 0;
   smp_t  z = '0;

   i2s_multi_capture_axis dut (
      .sck(sck), .rst(rst), .ws(ws), .sd(sd), .start(start), .stereo_en(stereo_en),
      .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tlast(tlast), .overflow(overflow), .short_err(short_err), .drop_cnt(drop_cnt)
`ifdef I2S_CAP_TUSER_EN
      , .m_axis_tuser(tuser)
`endif
   );

   always #5 sck = ~sck;

   // Sink ready pattern: 0 always, 1 stalled, 2 toggling, 3 random
   always @(posedge sck) begin
      #2;
      case (mode)
         0: tready = 1'b1;
         1: tready = 1'b0;
         2: tready = ~tready;
         default: tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Beat monitor: stall stability and scoreboard compare
   logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [127:0] pd = '0;
   always @(negedge sck) begin : mon
      beat_t e;
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", tvalid, tdata, tlast, pd, pl);
            end
         end
         if (tvalid && tready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: got d=%h l=%b want no beat", tdata, tlast);
            end else begin
               e = q.pop_front();
               if (tdata !== e.data || tlast !== e.last
`ifdef I2S_CAP_TUSER_EN
                   || tuser[0] !== e.user
`endif
               ) begin
                  n_fail++;
                  $display("FAIL beat: got d=%h l=%b want d=%h l=%b u=%b", tdata, tlast, e.data, e.last, e.user);
               end
            end
         end
         pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One ws half: edge at k=0, MSB..LSB on the next 24 rises, then zeros
   task automatic send_half(input logic wsv, input smp_t smp, input int len);
      for (int k = 0; k < len; k++) begin
         @(negedge sck);
         if (k == 0) ws = wsv;
         for (int c = 0; c < 8; c++) sd[c] = (k >= 1 && k <= 24) ? smp[c][24-k] : 1'b0;
      end
   endtask

   task automatic push_beats(input logic [127:0] b0, input logic [127:0] b1, input logic slot);
      beat_t b;
      b.data = b0; b.last = 1'b0; b.user = slot; q.push_back(b);
      b.data = b1; b.last = 1'b1; b.user = slot; q.push_back(b);
   endtask

   // Reference frame model: sign-extended 32-bit slots, channel 0 lowest
   task automatic push_frame(input smp_t smp, input logic slot);
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = {{8{smp[i][23]}}, smp[i]};
      push_beats(f[127:0], f[255:128], slot);
   endtask

   function automatic smp_t mk(input int f);
      smp_t s;
      for (int c = 0; c < 8; c++)
         s[c] = 24'(f * 24'h050403 + c * 24'h010101) ^ (((f + c) % 2 == 1) ? 24'h800000 : 24'h0);
      return s;
   endfunction

   task automatic wait_drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge sck);
         n++;
      end
      chk("drain_left", 128'(q.size()), 128'd0);
      q.delete();
      repeat (8) @(negedge sck);
   endtask

   task automatic do_reset();
      @(posedge sck); #3 rst = 1'b1; q.delete();
      @(posedge sck); #3 rst = 1'b0;
   endtask

   vec_t vecs[3];

   initial begin
      vecs[0].smp = {24'h222222, 24'h111111, 24'hFFFFFF, 24'hEEEEEE,
                     24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
      vecs[0].b0  = {32'hFFDDDDDD, 32'hFFCCCCCC, 32'hFFBBBBBB, 32'hFFAAAAAA};
      vecs[0].b1  = {32'h00222222, 32'h00111111, 32'hFFFFFFFF, 32'hFFEEEEEE};
      vecs[1].smp = {8{24'h123456}};
      vecs[1].b0  = {4{32'h00123456}};
      vecs[1].b1  = {4{32'h00123456}};
      vecs[2].smp = {24'hABCDEF, 24'h000000, 24'hC00000, 24'h400000,
                     24'hFFFFFF, 24'h000001, 24'h7FFFFF, 24'h800000};
      vecs[2].b0  = {32'hFFFFFFFF, 32'h00000001, 32'h007FFFFF, 32'hFF800000};
      vecs[2].b1  = {32'hFFABCDEF, 32'h00000000, 32'hFFC00000, 32'h00400000};

      // Reset state
      repeat (3) @(posedge sck);
      #3 rst = 1'b0;
      @(negedge sck);
      chk("rst_tvalid", 128'(tvalid), 128'd0);
      chk("rst_tlast", 128'(tlast), 128'd0);
      chk("rst_tdata", tdata, 128'd0);
      chk("rst_overflow", 128'(overflow), 128'd0);
      chk("rst_short_err", 128'(short_err), 128'd0);
      chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);

      // Table-driven mono frames
      start = 1'b1;
      repeat (4) @(negedge sck);
      for (int v = 0; v < 3; v++) begin
         push_beats(vecs[v].b0, vecs[v].b1, 1'b0);
         send_half(1'b0, vecs[v].smp, 32);
         send_half(1'b1, z, 32);
      end
      wait_drain(200);

      // Stereo: both slots captured, in order
      stereo_en = 1'b1;
      push_frame({8{24'h123456}}, 1'b0);
      send_half(1'b0, {8{24'h123456}}, 32);
      push_frame({8{24'h654321}}, 1'b1);
      send_half(1'b1, {8{24'h654321}}, 32);
      stereo_en = 1'b0;
      wait_drain(200);

      // Backpressure toggling then random mid-frame
      mode = 2;
      for (int f = 10; f < 15; f++) begin
         if (f == 13) mode = 3;
         push_frame(mk(f), 1'b0);
         send_half(1'b0, mk(f), 32);
         send_half(1'b1, z, 32);
      end
      wait_drain(400);
      mode = 0;

      // Short slot after 10 bits, then a good frame
      send_half(1'b0, mk(30), 11);
      send_half(1'b1, z, 32);
      push_frame(mk(31), 1'b0);
      send_half(1'b0, mk(31), 32);
      send_half(1'b1, z, 32);
      wait_drain(200);
      chk("short_err", 128'(short_err), 128'd1);
      chk("short_drop_cnt", 128'(drop_cnt), 128'd1);
      chk("short_no_overflow", 128'(overflow), 128'd0);

      // Overflow: sink stalled for five frames with a four-deep FIFO
      do_reset();
      mode = 1;
      send_half(1'b1, z, 32);
      for (int f = 0; f < 5; f++) begin
         if (f < 4) push_frame(mk(f), 1'b0);
         send_half(1'b0, mk(f), 32);
         send_half(1'b1, z, 32);
      end
      chk("ovf_flag", 128'(overflow), 128'd1);
      chk("ovf_drop_cnt", 128'(drop_cnt), 128'd1);
      chk("ovf_short_err", 128'(short_err), 128'd0);
      mode = 0;
      wait_drain(400);

      // Reset mid-SHIFT with two frames queued
      mode = 1;
      send_half(1'b0, mk(20), 32);
      send_half(1'b1, z, 32);
      send_half(1'b0, mk(21), 32);
      send_half(1'b1, z, 32);
      send_half(1'b0, mk(22), 12);
      chk("pre_rst_tvalid", 128'(tvalid), 128'd1);
      chk("pre_rst_drop_cnt", 128'(drop_cnt), 128'd1);
      @(posedge sck); #3 rst = 1'b1; q.delete();
      #1;
      chk("mid_rst_tvalid", 128'(tvalid), 128'd0);
      chk("mid_rst_tlast", 128'(tlast), 128'd0);
      chk("mid_rst_tdata", tdata, 128'd0);
      chk("mid_rst_overflow", 128'(overflow), 128'd0);
      chk("mid_rst_drop_cnt", 128'(drop_cnt), 128'd0);
      @(posedge sck); #3 rst = 1'b0;
      mode = 0;
      sd = '0;
      repeat (40) @(negedge sck);
      chk("post_rst_idle", 128'(tvalid), 128'd0);
      send_half(1'b1, z, 32);
      push_frame(mk(23), 1'b0);
      send_half(1'b0, mk(23), 32);
      send_half(1'b1, z, 32);
      wait_drain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
